rom_port_arbiter: RTL and testbench



---
 rtl/rom_arb_pkg.sv | 22 ++
 rtl/rom_port_arbiter_if.sv | 27 ++
 rtl/rom_line_cache.sv | 53 +++++
 rtl/rom_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_rom_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg
//   Shared types and constants for the ROM port arbiter and its line cache.
//   arb_state_t : arbiter FSM states
//   grant_t     : which side received the most recent grant (fairness memory)
//   LINE_BYTES  : bytes per cached/fetched line, LINE_SHIFT = log2(LINE_BYTES)
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_t;

   localparam int LINE_BYTES = 8;
   localparam int LINE_SHIFT = 3;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if
//   Toggle-handshake memory port between the arbiter and ddram.
//   master (arbiter) : drives mem_addr, mem_we, mem_din, mem_req
//                      receives mem_ack, mem_dout
//   slave  (ddram)   : the mirror image
interface rom_port_arbiter_if #(
   parameter int MEM_AW = 28
);

   logic [MEM_AW-1:0] mem_addr;
   logic              mem_we;
   logic [15:0]       mem_din;
   logic              mem_req;
   logic              mem_ack;
   logic [63:0]       mem_dout;

   modport master (
      output mem_addr, mem_we, mem_din, mem_req,
      input  mem_ack, mem_dout
   );

   modport slave (
      input  mem_addr, mem_we, mem_din, mem_req,
      output mem_ack, mem_dout
   );

endinterface

// File: rtl/rom_line_cache.sv
// rom_line_cache
//   Single-line read cache: valid bit, tag (read line address) and line data.
//   lookup_tag -> hit     : combinational hit compare, line is the cached data
//   tag_ld / tag_in       : latch a new tag at a miss grant (drops valid)
//   fill / fill_data      : store returned line and mark it valid
//   inv / inv_line        : drop valid if a completed write touched the line
//   flush                 : drop valid unconditionally (wins over fill)
module rom_line_cache
   import rom_arb_pkg::*;
#(
   parameter int TAG_W = 20,
   parameter int INV_W = 22
) (
   input  logic                    clk_sys,
   input  logic                    reset_n,
   input  logic [TAG_W-1:0]        lookup_tag,
   output logic                    hit,
   output logic [LINE_BYTES*8-1:0] line,
   input  logic                    tag_ld,
   input  logic [TAG_W-1:0]        tag_in,
   input  logic                    fill,
   input  logic [LINE_BYTES*8-1:0] fill_data,
   input  logic                    inv,
   input  logic [INV_W-1:0]        inv_line,
   input  logic                    flush
);

   // Write line address and tag can differ in width; compare zero-extended.
   localparam int CMP_W = (TAG_W > INV_W) ? TAG_W : INV_W;

   logic             valid;
   logic [TAG_W-1:0] tag;
   logic             inv_match;

   assign hit       = valid && (tag == lookup_tag);
   assign inv_match = inv && (CMP_W'(inv_line) == CMP_W'(tag));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         tag   <= '0;
         line  <= '0;
      end else begin
         if (tag_ld) tag  <= tag_in;
         if (fill)   line <= fill_data;
         // The old line is meaningless once a new tag is latched, so a miss
         // grant drops valid until the fill lands.
         if (flush || tag_ld || inv_match) valid <= 1'b0;
         else if (fill)                    valid <= 1'b1;
      end
   end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares one toggle-handshake DDR3 port between the ROM download writer and
//   the core's ROM line reader, with a one-line read cache in front.
//   clk_sys, reset_n            : clock, async active-low reset
//   flush                       : pulse to invalidate the line cache
//   wr_addr/wr_data/wr_req/wr_ack : 16-bit download writes (toggle handshake)
//   rd_addr/rd_req/rd_ack/rd_data : 64-bit line reads (toggle handshake)
//   mem                         : memory port toward ddram (master side)
//   busy                        : high whenever a memory access is in flight
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int WR_AW  = 25,
   parameter int RD_AW  = 20,
   parameter int MEM_AW = 28
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic [WR_AW-1:0]      wr_addr,
   input  logic [15:0]           wr_data,
   input  logic                  wr_req,
   output logic                  wr_ack,
   input  logic [RD_AW-1:0]      rd_addr,
   input  logic                  rd_req,
   output logic                  rd_ack,
   output logic [63:0]           rd_data,
   rom_port_arbiter_if.master    mem,
   output logic                  busy
);

   arb_state_t        state, state_nxt;
   grant_t            last_grant, last_grant_nxt;
   logic              wr_ack_nxt, rd_ack_nxt, mem_req_nxt, mem_we_nxt;
   logic [MEM_AW-1:0] mem_addr_nxt;
   logic [15:0]       mem_din_nxt;
   logic [63:0]       rd_data_nxt;

   logic              wr_pend, rd_pend, rd_wins, mem_done;
   logic              hit, tag_ld, fill, inv;
   logic [63:0]       cache_line;

   assign wr_pend  = wr_req != wr_ack;
   assign rd_pend  = rd_req != rd_ack;
   assign mem_done = mem.mem_ack == mem.mem_req;
   // Read takes the slot if it is alone, or if the write had the last turn.
   assign rd_wins  = rd_pend && (!wr_pend || last_grant == GRANT_WR);
   assign busy     = state != IDLE;

   rom_line_cache #(
      .TAG_W (RD_AW),
      .INV_W (WR_AW - LINE_SHIFT)
   ) u_cache (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .lookup_tag (rd_addr),
      .hit        (hit),
      .line       (cache_line),
      .tag_ld     (tag_ld),
      .tag_in     (rd_addr),
      .fill       (fill),
      .fill_data  (mem.mem_dout),
      .inv        (inv),
      .inv_line   (wr_addr[WR_AW-1:LINE_SHIFT]),
      .flush      (flush)
   );

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      wr_ack_nxt     = wr_ack;
      rd_ack_nxt     = rd_ack;
      mem_req_nxt    = mem.mem_req;
      mem_we_nxt     = mem.mem_we;
      mem_addr_nxt   = mem.mem_addr;
      mem_din_nxt    = mem.mem_din;
      rd_data_nxt    = rd_data;
      tag_ld         = 1'b0;
      fill           = 1'b0;
      inv            = 1'b0;

      case (state)
         IDLE: begin
            if (rd_wins && hit) begin
               rd_data_nxt    = cache_line;
               rd_ack_nxt     = ~rd_ack;
               last_grant_nxt = GRANT_RD;
            end else if (wr_pend && !rd_wins) begin
               mem_addr_nxt = MEM_AW'({wr_addr[WR_AW-1:1], 1'b0});
               mem_din_nxt  = wr_data;
               mem_we_nxt   = 1'b1;
               mem_req_nxt  = ~mem.mem_req;
               state_nxt    = WR_WAIT;
            end else if (rd_wins) begin
               mem_addr_nxt = MEM_AW'({rd_addr, {LINE_SHIFT{1'b0}}});
               mem_we_nxt   = 1'b0;
               mem_req_nxt  = ~mem.mem_req;
               tag_ld       = 1'b1;
               state_nxt    = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (mem_done) begin
               wr_ack_nxt     = ~wr_ack;
               inv            = 1'b1;
               last_grant_nxt = GRANT_WR;
               state_nxt      = IDLE;
            end
         end
         RD_WAIT: begin
            if (mem_done) begin
               rd_data_nxt    = mem.mem_dout;
               fill           = 1'b1;
               rd_ack_nxt     = ~rd_ack;
               last_grant_nxt = GRANT_RD;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         last_grant   <= GRANT_RD;   // first contended grant goes to the write
         wr_ack       <= 1'b0;
         rd_ack       <= 1'b0;
         rd_data      <= '0;
         mem.mem_req  <= 1'b0;
         mem.mem_we   <= 1'b0;
         mem.mem_addr <= '0;
         mem.mem_din  <= '0;
      end else begin
         state        <= state_nxt;
         last_grant   <= last_grant_nxt;
         wr_ack       <= wr_ack_nxt;
         rd_ack       <= rd_ack_nxt;
         rd_data      <= rd_data_nxt;
         mem.mem_req  <= mem_req_nxt;
         mem.mem_we   <= mem_we_nxt;
         mem.mem_addr <= mem_addr_nxt;
         mem.mem_din  <= mem_din_nxt;
      end
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
//   Directed scenarios followed by randomized traffic. Expected read lines come
//   from a reference memory (line-addressed array updated at write issue);
//   a separate ddram model stores what the DUT actually writes and serves reads.
module tb_rom_port_arbiter;
   import rom_arb_pkg::*;

   localparam int WR_AW  = 25;
   localparam int RD_AW  = 20;
   localparam int MEM_AW = 28;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              flush;
   logic [WR_AW-1:0]  wr_addr = '0;
   logic [15:0]       wr_data = '0;
   logic              wr_req  = 1'b0;
   logic              wr_ack;
   logic [RD_AW-1:0]  rd_addr = '0;
   logic              rd_req  = 1'b0;
   logic              rd_ack;
   logic [63:0]       rd_data;
   logic              busy;

   rom_port_arbiter_if #(.MEM_AW(MEM_AW)) mif ();

   rom_port_arbiter #(.WR_AW(WR_AW), .RD_AW(RD_AW), .MEM_AW(MEM_AW)) dut (
      .clk_sys (clk_sys), .reset_n (reset_n), .flush (flush),
      .wr_addr (wr_addr), .wr_data (wr_data), .wr_req (wr_req), .wr_ack (wr_ack),
      .rd_addr (rd_addr), .rd_req (rd_req), .rd_ack (rd_ack), .rd_data (rd_data),
      .mem (mif), .busy (busy)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int failures = 0;

   logic [63:0]       ref_mem [int];
   logic [63:0]       ddr_mem [int];
   logic [63:0]       rd_q [$];
   logic [MEM_AW-1:0] wr_q_addr [$];
   logic [15:0]       wr_q_din [$];
   logic              log_we [$];
   logic [MEM_AW-1:0] log_addr [$];
   logic [15:0]       log_din [$];
   int                mem_txns = 0;
   int                mem_lat = 5;
   int                flush_at_txn = -1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] init_line(input int k);
      return {32'(k) ^ 32'hCAFE_0000, ~32'(k)};
   endfunction

   function automatic logic [63:0] ref_line(input int k);
      return ref_mem.exists(k) ? ref_mem[k] : init_line(k);
   endfunction

   function automatic logic [63:0] ddr_line(input int k);
      return ddr_mem.exists(k) ? ddr_mem[k] : init_line(k);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] l, input int w, input logic [15:0] d);
      logic [63:0] r;
      r = l;
      r[w*16 +: 16] = d;
      return r;
   endfunction

   function automatic logic log_we_at(input int i);
      return (i < log_we.size()) ? log_we[i] : 1'bx;
   endfunction

   // Issue helpers: call right after a negedge; several may share one edge.
   task automatic issue_rd(input int line);
      rd_addr = RD_AW'(line);
      rd_req  = ~rd_req;
      rd_q.push_back(ref_line(line));
   endtask

   task automatic issue_wr(input int a, input logic [15:0] d);
      wr_addr = WR_AW'(a);
      wr_data = d;
      wr_req  = ~wr_req;
      wr_q_addr.push_back(MEM_AW'(a & ~1));
      wr_q_din.push_back(d);
      ref_mem[a >> 3] = merge(ref_line(a >> 3), (a >> 1) & 3, d);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (!(rd_req == rd_ack && wr_req == wr_ack && !busy) && n < 300);
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL %s: timeout waiting for acks, got busy=%b expected idle", nm, busy);
      end
   endtask

   // ddram model: acks mem_lat cycles after seeing a request (random if 0).
   initial begin
      logic cur_we;
      int   cur_line, cnt;
      logic mbusy;
      mbusy = 1'b0; cnt = 0; cur_we = 1'b0; cur_line = 0;
      mif.mem_ack = 1'b0; mif.mem_dout = '0; flush = 1'b0;
      forever begin
         @(negedge clk_sys);
         flush = 1'b0;
         if (!reset_n) begin
            mif.mem_ack = 1'b0;
            mbusy = 1'b0;
         end else if (mbusy) begin
            cnt--;
            if (cnt == 0) begin
               if (!cur_we) begin
                  mif.mem_dout = ddr_line(cur_line);
                  if (mem_txns == flush_at_txn) flush = 1'b1;
               end
               mif.mem_ack = ~mif.mem_ack;
               mbusy = 1'b0;
            end
         end else if (mif.mem_req != mif.mem_ack) begin
            mem_txns++;
            cur_we   = mif.mem_we;
            cur_line = int'(mif.mem_addr >> 3);
            log_we.push_back(mif.mem_we);
            log_addr.push_back(mif.mem_addr);
            log_din.push_back(mif.mem_din);
            if (cur_we) begin
               if (wr_q_addr.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL wr_unexpected: got write to %h expected none", mif.mem_addr);
               end else begin
                  chk("wr_mem_addr", 64'(mif.mem_addr), 64'(wr_q_addr.pop_front()));
                  chk("wr_mem_din", 64'(mif.mem_din), 64'(wr_q_din.pop_front()));
               end
               ddr_mem[cur_line] = merge(ddr_line(cur_line), int'(mif.mem_addr[2:1]), mif.mem_din);
            end
            cnt   = (mem_lat == 0) ? int'($urandom_range(1, 6)) : mem_lat;
            mbusy = 1'b1;
         end
      end
   end

   // Read monitor: every rd_ack toggle must deliver the next expected line.
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (!reset_n) prev = 1'b0;
         else if (rd_ack !== prev) begin
            prev = rd_ack;
            if (rd_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rd_unexpected: got ack with data %h expected none", rd_data);
            end else chk("rd_data", rd_data, rd_q.pop_front());
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, t0;
      // reset state
      repeat (3) @(negedge clk_sys);
      chk("rst_wr_ack", 64'(wr_ack), 0);
      chk("rst_rd_ack", 64'(rd_ack), 0);
      chk("rst_mem_req", 64'(mif.mem_req), 0);
      chk("rst_mem_we", 64'(mif.mem_we), 0);
      chk("rst_mem_addr", 64'(mif.mem_addr), 0);
      chk("rst_mem_din", 64'(mif.mem_din), 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", 64'(busy), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // miss on line 0x10
      ddr_mem['h10] = 64'h1122334455667788;
      ref_mem['h10] = 64'h1122334455667788;
      t0 = mem_txns;
      @(negedge clk_sys); issue_rd('h10);
      wait_idle("miss1");
      chk("miss1_txn", 64'(mem_txns), 64'(t0 + 1));
      chk("miss1_addr", 64'(log_addr[$]), 64'h80);
      chk("miss1_we", 64'(log_we[$]), 0);
      chk("miss1_rd_ack", 64'(rd_ack), 1);
      chk("miss1_rd_data", rd_data, 64'h1122334455667788);

      // re-read hits in one cycle with no memory traffic
      t0 = mem_txns;
      @(negedge clk_sys); issue_rd('h10);
      @(negedge clk_sys);
      chk("hit_latency", 64'(rd_ack), 0);
      chk("hit_no_mem", 64'(mem_txns), 64'(t0));

      // write into the cached line invalidates it
      @(negedge clk_sys); issue_wr('h84, 16'hBEEF);
      wait_idle("wr84");
      chk("wr84_din", 64'(log_din[$]), 64'hBEEF);
      chk("wr84_we", 64'(log_we[$]), 1);
      chk("wr84_addr", 64'(log_addr[$]), 64'h84);
      t0 = mem_txns;
      @(negedge clk_sys); issue_rd('h10);
      wait_idle("reread10");
      chk("reread10_miss", 64'(mem_txns), 64'(t0 + 1));
      chk("reread10_data", rd_data, 64'h1122BEEF55667788);

      // contended pair after a read: write first
      n0 = log_we.size();
      @(negedge clk_sys); issue_rd('h30); issue_wr('h20 * 8, 16'h1234);
      wait_idle("pair1");
      chk("pair1_first_wr", 64'(log_we_at(n0)), 1);
      chk("pair1_second_rd", 64'(log_we_at(n0 + 1)), 0);
      // lone write, then contended pair: read first
      @(negedge clk_sys); issue_wr('h40 * 8 + 4, 16'h4444);
      wait_idle("lone_wr");
      n0 = log_we.size();
      @(negedge clk_sys); issue_rd('h60); issue_wr('h50 * 8 + 2, 16'h5678);
      wait_idle("pair2");
      chk("pair2_first_rd", 64'(log_we_at(n0)), 0);
      chk("pair2_second_wr", 64'(log_we_at(n0 + 1)), 1);

      // flush on the fill edge: data delivered, line not retained
      flush_at_txn = mem_txns + 1;
      @(negedge clk_sys); issue_rd('h70);
      wait_idle("flush_fill");
      flush_at_txn = -1;
      t0 = mem_txns;
      @(negedge clk_sys); issue_rd('h70);
      wait_idle("flush_reread");
      chk("flush_reread_miss", 64'(mem_txns), 64'(t0 + 1));

      // reset while in RD_WAIT
      @(negedge clk_sys); issue_rd('h80);
      repeat (2) @(negedge clk_sys);
      chk("rst_mid_busy_before", 64'(busy), 1);
      reset_n = 1'b0;
      rd_req = 1'b0;
      wr_req = 1'b0;
      rd_q.delete();
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("rst_mid_rd_ack", 64'(rd_ack), 0);
      chk("rst_mid_wr_ack", 64'(wr_ack), 0);
      chk("rst_mid_mem_req", 64'(mif.mem_req), 0);
      chk("rst_mid_busy", 64'(busy), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      t0 = mem_txns;
      @(negedge clk_sys); issue_rd('h10);
      wait_idle("post_rst_read");
      chk("post_rst_miss", 64'(mem_txns), 64'(t0 + 1));
      chk("post_rst_rd_ack", 64'(rd_ack), 1);

      // randomized traffic over a small line window to mix hits, misses, invalidates
      mem_lat = 0;
      for (int it = 0; it < 150; it++) begin
         int op, rl, wa;
         op = int'($urandom_range(0, 2));
         rl = 'h100 + int'($urandom_range(0, 7));
         wa = ('h100 + int'($urandom_range(0, 7))) * 8 + 2 * int'($urandom_range(0, 3));
         if (op == 2)
            while ((wa >> 3) == rl) rl = 'h100 + int'($urandom_range(0, 7));
         @(negedge clk_sys);
         if (op != 1) issue_rd(rl);
         if (op != 0) issue_wr(wa, 16'($urandom));
         wait_idle("rand");
         repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      end

      repeat (3) @(negedge clk_sys);
      chk("rd_q_drained", 64'(rd_q.size()), 0);
      chk("wr_q_drained", 64'(wr_q_addr.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
